updown_mod_counter: RTL

Parametrised synchronous successor to our 4-bit ripple counter. All count bits change on one clock edge, so there are no ripple glitches on count. It adds direction control, programmable modulus, parallel load, wrap or saturate mode, a terminal-count flag, a wrap pulse and a sticky overflow flag. It is used as the general-purpose event/divider counter in lab designs and feeds timers and display drivers.

---
 rtl/counter_pkg.sv | 17 +
 rtl/counter_next_value.sv | 57 +++++
 rtl/updown_mod_counter.sv | 79 +++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Constants and helpers shared by the up/down modulus counter and the timer
// blocks built on top of it.
package counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // Limits a requested value to the legal range 0..modulus-1.
    function automatic logic [31:0] clamp_to_modulus(input logic [31:0] value,
                                                     input logic [31:0] modulus);
        return (value < modulus) ? value : (modulus - 32'd1);
    endfunction

endpackage

// File: rtl/counter_next_value.sv
// Combinational next-state logic for updown_mod_counter: clear > load > step > hold,
// with the range-end wrap/saturate decision and its wrap event.
module counter_next_value
    import counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int SATURATE = 0
) (
    input  logic [WIDTH-1:0] count,
    input  logic             up_down,
    input  logic             toggle,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             clear,
    output logic [WIDTH-1:0] next_count,
    output logic             wrap_event
);

    localparam logic [WIDTH:0]   MOD_EXT   = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULUS - 1);

    // One extra bit lets MODULUS == 2**WIDTH compare correctly and exposes the
    // borrow out of zero when stepping down.
    logic [WIDTH:0] inc_ext;
    logic [WIDTH:0] dec_ext;

    assign inc_ext = {1'b0, count} + (WIDTH+1)'(1);
    assign dec_ext = {1'b0, count} - (WIDTH+1)'(1);

    always_comb begin
        next_count = count;
        wrap_event = 1'b0;
        if (clear) begin
            next_count = '0;
        end else if (load) begin
            next_count = WIDTH'(clamp_to_modulus(32'(load_value), 32'(MODULUS)));
        end else if (toggle) begin
            if (up_down == DIR_UP) begin
                if (inc_ext >= MOD_EXT) begin
                    wrap_event = 1'b1;
                    next_count = (SATURATE == MODE_SAT) ? count : '0;
                end else begin
                    next_count = inc_ext[WIDTH-1:0];
                end
            end else begin
                if (dec_ext[WIDTH]) begin
                    wrap_event = 1'b1;
                    next_count = (SATURATE == MODE_SAT) ? count : MAX_COUNT;
                end else begin
                    next_count = dec_ext[WIDTH-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/updown_mod_counter.sv
// Synchronous up/down modulus counter with load, clear, wrap/saturate mode,
// terminal-count flag, one-cycle wrap pulse and sticky overflow.
module updown_mod_counter
    import counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int SATURATE = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             toggle,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             clear,
    input  logic             ovf_clear,
    output logic [WIDTH-1:0] count,
    output logic             terminal,
    output logic             wrap_pulse,
    output logic             overflow
);

    if (WIDTH < 1 || WIDTH > 31 || MODULUS < 2 ||
        longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_params
        $fatal(1, "updown_mod_counter: illegal WIDTH/MODULUS combination");
    end

    localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] count_d, count_q;
    logic             wrap_pulse_d, wrap_pulse_q;
    logic             overflow_d, overflow_q;
    logic             wrap_event;

    counter_next_value #(
        .WIDTH    (WIDTH),
        .MODULUS  (MODULUS),
        .SATURATE (SATURATE)
    ) u_next (
        .count      (count_q),
        .up_down    (up_down),
        .toggle     (toggle),
        .load       (load),
        .load_value (load_value),
        .clear      (clear),
        .next_count (count_d),
        .wrap_event (wrap_event)
    );

    // A wrap event in the same cycle as ovf_clear keeps the flag set.
    always_comb begin
        wrap_pulse_d = wrap_event;
        overflow_d   = overflow_q;
        if (wrap_event) begin
            overflow_d = 1'b1;
        end else if (ovf_clear) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q      <= '0;
            wrap_pulse_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            count_q      <= count_d;
            wrap_pulse_q <= wrap_pulse_d;
            overflow_q   <= overflow_d;
        end
    end

    assign count      = count_q;
    assign wrap_pulse = wrap_pulse_q;
    assign overflow   = overflow_q;
    assign terminal   = (up_down == DIR_UP) ? (count_q == MAX_COUNT) : (count_q == '0);

endmodule
